data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Parametrised, byte-addressed, big-endian data memory for the MIPS datapath.
- Next generation of the single-cycle word memory: adds byte/half/word access sizes, sign/zero extension on loads, alignment and range checking, and a configurable wait-state handshake.
- Sits between the MEM pipeline stage and the storage array; the stage stalls on `busy` and samples results on `done`.

Parameters:
- ADDR_W, 32: width of the byte address.
- DEPTH, 1024: number of 32-bit words stored; valid word index range is 0..DEPTH-1.
- LATENCY, 2: wait states inserted between request acceptance and completion; legal range 0..15.

Ports:
- clock  input  1  single system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  request valid; sampled only in IDLE.
- rw  input  1  1 = read (load), 0 = write (store).
- size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal and raises err.
- sign_ext  input  1  loads only: 1 sign-extends byte/half, 0 zero-extends.
- w_addr  input  ADDR_W  byte address.
- w_data_in_32  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- w_data_out_32  output  32  load result, extended to 32 bits.
- busy  output  1  high from the cycle after acceptance until done is deasserted.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid only with done; high for misaligned, out-of-range or illegal-size requests.

Behaviour:
- Reset (asynchronous): FSM to IDLE; w_data_out_32, busy, done, err and the wait counter cleared to 0. Array contents are undefined and not cleared.
- FSM states: IDLE, WAIT, DONE.
- IDLE with en=1: latch rw, size, sign_ext, w_addr and w_data_in_32, then:
  - Request invalid: go to DONE with err=1.
  - LATENCY=0: go straight to DONE.
  - Otherwise: load the counter with LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle; at 0, go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE. A new request may be accepted in the cycle after DONE (IDLE).
- Latency: done rises LATENCY+1 cycles after the accepting edge.
- en while busy: ignored; requests are not queued. Inputs may change freely after acceptance.
- Request validity:
  - Misaligned: half with addr[0]!=0, or word with addr[1:0]!=0.
  - Out of range: word index addr[ADDR_W-1:2] >= DEPTH.
  - Illegal size: size=11.
  - Invalid requests leave the array unmodified and leave w_data_out_32 unchanged.
- Lane mapping (big-endian): addr[1:0]=0 selects bits [31:24] of the word; addr[1:0]=3 selects [7:0]. Halfword addr[1]=0 selects [31:16].
- Stores: the write commits on the edge entering DONE and updates only the selected byte lanes; other lanes are preserved (read-modify-write or byte enables).
- Loads: w_data_out_32 is registered on the edge entering DONE and holds until the next successful load completes. Stores do not alter it.
- Reset mid-operation: the pending request is aborted. A store not yet at its commit edge must not modify the array. done is not asserted.

Test Plan:
- Reset, then word store 0xABCDABCD @0x0, 0xDEFADEFA @0x4, 0x12341234 @0x8; word loads from the same addresses -> outputs 0xABCDABCD, 0xDEFADEFA, 0x12341234; each done exactly 3 cycles after en with LATENCY=2; err=0.
- Word 0x11223344 @0x10; byte store 0xAA @0x12 -> word load @0x10 returns 0x1122AA44.
- Word 0x80FF7F01 @0x20; loads:
  - byte @0x20, sign_ext=1 -> 0xFFFFFF80.
  - byte @0x20, sign_ext=0 -> 0x00000080.
  - half @0x22, sign_ext=1 -> 0x00007F01.
  - half @0x20, sign_ext=1 -> 0xFFFF80FF.
- Error cases:
  - Word store @0x6 -> done with err=1; word @0x4 unchanged.
  - Half load @0x21 -> err=1; w_data_out_32 unchanged.
  - Word load @DEPTH*4 -> err=1.
  - size=11 -> err=1.
- Pulse en every cycle for 8 cycles -> exactly 2 requests accepted (at accept, accept+4); busy high for LATENCY+1 cycles per request; no extra done.
- Start a store of 0x55555555 @0x4 over existing 0xDEFADEFA; assert reset in the WAIT cycle -> done never rises, all outputs 0; a later load @0x4 returns 0xDEFADEFA. With LATENCY=0, a store completes with done 1 cycle after en.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Byte-addressed big-endian data memory controller with byte/half/word access,
// load sign/zero extension, alignment and range checking, and fixed wait states.
module data_mem_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [31:0]       w_data_in_32,
  output logic [31:0]       w_data_out_32,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t state, state_nx;
  logic [3:0]        cnt;
  logic              rw_q, sx_q, inv_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;

  logic              cur_rw, cur_sx, cur_inv, inv_in, commit;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_data, rd_word, wr_word, ld_word;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  logic [31:0] mem [DEPTH];

  // Validity of the request currently on the inputs.
  always_comb begin
    inv_in = 1'b0;
    case (size)
      2'b01:   inv_in = w_addr[0];
      2'b10:   inv_in = |w_addr[1:0];
      2'b11:   inv_in = 1'b1;
      default: inv_in = 1'b0;
    endcase
    if ({2'b00, w_addr[ADDR_W-1:2]} >= DEPTH_W) inv_in = 1'b1;
  end

  // Commit can happen on the accepting edge itself (LATENCY=0 or invalid),
  // so the live inputs stand in for the latched request while in IDLE.
  always_comb begin
    if (state == IDLE) begin
      cur_rw   = rw;
      cur_sx   = sign_ext;
      cur_inv  = inv_in;
      cur_size = size;
      cur_addr = w_addr;
      cur_data = w_data_in_32;
    end else begin
      cur_rw   = rw_q;
      cur_sx   = sx_q;
      cur_inv  = inv_q;
      cur_size = size_q;
      cur_addr = addr_q;
      cur_data = data_q;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE: if (en) state_nx = (inv_in || LATENCY == 0) ? DONE : WAIT;
      WAIT: if (cnt == 4'd0) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign commit = (state != DONE) && (state_nx == DONE) && !reset;

  assign rd_word = mem[cur_addr[IDX_W+1:2]];

  always_comb begin
    byte_v = 8'h00;
    case (cur_addr[1:0])
      2'd0: byte_v = rd_word[31:24];
      2'd1: byte_v = rd_word[23:16];
      2'd2: byte_v = rd_word[15:8];
      2'd3: byte_v = rd_word[7:0];
      default: byte_v = 8'h00;
    endcase
    half_v = cur_addr[1] ? rd_word[15:0] : rd_word[31:16];

    case (cur_size)
      2'b00:   ld_word = {{24{cur_sx & byte_v[7]}}, byte_v};
      2'b01:   ld_word = {{16{cur_sx & half_v[15]}}, half_v};
      default: ld_word = rd_word;
    endcase

    // Read-modify-write: untouched lanes come from the current word.
    wr_word = rd_word;
    case (cur_size)
      2'b00: begin
        case (cur_addr[1:0])
          2'd0: wr_word[31:24] = cur_data[7:0];
          2'd1: wr_word[23:16] = cur_data[7:0];
          2'd2: wr_word[15:8]  = cur_data[7:0];
          2'd3: wr_word[7:0]   = cur_data[7:0];
          default: wr_word = rd_word;
        endcase
      end
      2'b01: begin
        if (cur_addr[1]) wr_word[15:0]  = cur_data[15:0];
        else             wr_word[31:16] = cur_data[15:0];
      end
      default: wr_word = cur_data;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      rw_q          <= 1'b0;
      sx_q          <= 1'b0;
      inv_q         <= 1'b0;
      size_q        <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      err           <= 1'b0;
      w_data_out_32 <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && en) begin
        rw_q   <= rw;
        sx_q   <= sign_ext;
        inv_q  <= inv_in;
        size_q <= size;
        addr_q <= w_addr;
        data_q <= w_data_in_32;
        cnt    <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        err <= cur_inv;
        if (cur_rw && !cur_inv) w_data_out_32 <= ld_word;
      end else if (state == DONE) begin
        err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (commit && !cur_rw && !cur_inv) mem[cur_addr[IDX_W+1:2]] <= wr_word;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed requests push expectations,
// a negedge monitor checks each done pulse for err, data and cycle.
module tb_data_mem_ctrl;

  localparam int LAT = 2;

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] data;
    int unsigned cyc;
    string       name;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset, en, en0, rw, sign_ext;
  logic [1:0]  size;
  logic [31:0] w_addr, din;
  logic [31:0] dout, dout0;
  logic        busy, done, err, busy0, done0, err0;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  data_mem_ctrl #(.ADDR_W(32), .DEPTH(1024), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .en(en), .rw(rw), .size(size),
    .sign_ext(sign_ext), .w_addr(w_addr), .w_data_in_32(din),
    .w_data_out_32(dout), .busy(busy), .done(done), .err(err)
  );

  data_mem_ctrl #(.ADDR_W(32), .DEPTH(1024), .LATENCY(0)) dut0 (
    .clock(clock), .reset(reset), .en(en0), .rw(rw), .size(size),
    .sign_ext(sign_ext), .w_addr(w_addr), .w_data_in_32(din),
    .w_data_out_32(dout0), .busy(busy0), .done(done0), .err(err0)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    exp_t x;
    if (done) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, required no completion", cyc);
      end else begin
        x = exp_q.pop_front();
        if (err !== x.err || cyc != x.cyc || (x.chk && dout !== x.data)) begin
          n_fail++;
          $display("FAIL %s: err=%b data=%h cycle=%0d, required err=%b data=%h cycle=%0d",
                   x.name, err, dout, cyc, x.err, x.data, x.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy && !done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: busy=%b, required idle within 40 cycles", name, busy);
    end
  endtask

  task automatic do_req(input string name, input logic r, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] d,
                        input logic e_err, input logic c, input logic [31:0] e_data);
    exp_t x;
    @(negedge clock);
    rw = r; size = sz; sign_ext = sx; w_addr = a; din = d;
    x.err  = e_err;
    x.chk  = c;
    x.data = e_data;
    x.cyc  = cyc + (e_err ? 1 : LAT + 1);
    x.name = name;
    exp_q.push_back(x);
    en = 1'b1;
    @(negedge clock);
    en = 1'b0;
    rw = ~r; din = 32'hFFFF_FFFF; w_addr = 32'h0000_0ffc;
    wait_idle(name);
  endtask

  initial begin
    exp_t x;
    int   bcnt;
    reset = 1'b1; en = 1'b0; en0 = 1'b0; rw = 1'b0; size = 2'b10;
    sign_ext = 1'b0; w_addr = '0; din = '0;
    repeat (2) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err",  {31'd0, err},  32'd0);
    chk("rst_data", dout, 32'd0);
    reset = 1'b0;

    do_req("st_w0", 0, 2'b10, 0, 32'h00, 32'hABCDABCD, 0, 0, 0);
    do_req("st_w4", 0, 2'b10, 0, 32'h04, 32'hDEFADEFA, 0, 0, 0);
    do_req("st_w8", 0, 2'b10, 0, 32'h08, 32'h12341234, 0, 0, 0);
    do_req("ld_w0", 1, 2'b10, 0, 32'h00, 0, 0, 1, 32'hABCDABCD);
    do_req("ld_w4", 1, 2'b10, 0, 32'h04, 0, 0, 1, 32'hDEFADEFA);
    do_req("ld_w8", 1, 2'b10, 0, 32'h08, 0, 0, 1, 32'h12341234);

    do_req("st_w10", 0, 2'b10, 0, 32'h10, 32'h11223344, 0, 0, 0);
    do_req("st_b12", 0, 2'b00, 0, 32'h12, 32'h000000AA, 0, 1, 32'h12341234);
    do_req("ld_w10", 1, 2'b10, 0, 32'h10, 0, 0, 1, 32'h1122AA44);

    do_req("st_w20",    0, 2'b10, 0, 32'h20, 32'h80FF7F01, 0, 0, 0);
    do_req("ld_b20_sx", 1, 2'b00, 1, 32'h20, 0, 0, 1, 32'hFFFFFF80);
    do_req("ld_b20_zx", 1, 2'b00, 0, 32'h20, 0, 0, 1, 32'h00000080);
    do_req("ld_h22_sx", 1, 2'b01, 1, 32'h22, 0, 0, 1, 32'h00007F01);
    do_req("ld_h20_sx", 1, 2'b01, 1, 32'h20, 0, 0, 1, 32'hFFFF80FF);

    do_req("err_st_w6",   0, 2'b10, 0, 32'h06, 32'h99999999, 1, 1, 32'hFFFF80FF);
    do_req("ld_w4_keep",  1, 2'b10, 0, 32'h04, 0, 0, 1, 32'hDEFADEFA);
    do_req("err_ld_h21",  1, 2'b01, 1, 32'h21, 0, 1, 1, 32'hDEFADEFA);
    do_req("err_ld_rng",  1, 2'b10, 0, 32'h1000, 0, 1, 1, 32'hDEFADEFA);
    do_req("err_size11",  1, 2'b11, 0, 32'h00, 0, 1, 1, 32'hDEFADEFA);

    // en held for 8 cycles: only two requests may be taken.
    @(negedge clock);
    rw = 1'b1; size = 2'b10; sign_ext = 1'b0; w_addr = 32'h0;
    x.err = 1'b0; x.chk = 1'b1; x.data = 32'hABCDABCD;
    x.cyc = cyc + 3; x.name = "pulse_a"; exp_q.push_back(x);
    x.cyc = cyc + 7; x.name = "pulse_b"; exp_q.push_back(x);
    en = 1'b1;
    bcnt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (busy) bcnt++;
      if (i == 8) en = 1'b0;
    end
    wait_idle("pulse");
    chk("pulse_busy_cycles", bcnt, 32'd6);
    chk("pulse_queue_empty", exp_q.size(), 32'd0);

    // Store aborted by reset while waiting must not reach the array.
    @(negedge clock);
    rw = 1'b0; size = 2'b10; w_addr = 32'h04; din = 32'h55555555;
    en = 1'b1;
    @(negedge clock);
    en = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_err",  {31'd0, err},  32'd0);
    chk("abort_data", dout, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    do_req("ld_w4_abort", 1, 2'b10, 0, 32'h04, 0, 0, 1, 32'hDEFADEFA);

    @(negedge clock);
    rw = 1'b0; size = 2'b10; w_addr = 32'h08; din = 32'hCAFEF00D;
    en0 = 1'b1;
    @(negedge clock);
    en0 = 1'b0;
    chk("lat0_st_done", {31'd0, done0}, 32'd1);
    chk("lat0_st_err",  {31'd0, err0},  32'd0);
    @(negedge clock);
    chk("lat0_done_pulse", {31'd0, done0}, 32'd0);
    rw = 1'b1;
    en0 = 1'b1;
    @(negedge clock);
    en0 = 1'b0;
    chk("lat0_ld_done", {31'd0, done0}, 32'd1);
    chk("lat0_ld_data", dout0, 32'hCAFEF00D);

    repeat (4) @(negedge clock);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
